// File: rtl/timer_bar_gen.sv
// timer_bar_gen
//   Round countdown timer plus per-pixel overlay flags for the on-screen
//   timer bar. The countdown runs in whole seconds (sec_left) and, in
//   parallel, shrinks a fill width by one pixel every PIX_TICKS clocks so the
//   bar empties smoothly over the round.
//   Ports:
//     clk, reset_n            pixel clock, asynchronous active-low reset
//     x_pixel, y_pixel, DE    current raster position and active-video flag
//     frame_tick              start of vertical blanking (display latch strobe)
//     start, hold, clear      round control (clear > start > hold)
//     timer_area, timer_left  registered pixel flags (1-cycle latency)
//     sec_left, time_out      remaining seconds, one-cycle expiry pulse
//     running                 high while the countdown is in RUN
module timer_bar_gen #(
  parameter int unsigned CLK_HZ   = 32'd25_000_000,
  parameter int unsigned TIME_SEC = 32'd60,
  parameter int unsigned BAR_X0   = 32'd20,
  parameter int unsigned BAR_Y0   = 32'd10,
  parameter int unsigned BAR_W    = 32'd600,
  parameter int unsigned BAR_H    = 32'd12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic       DE,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       hold,
  input  logic       clear,
  output logic       timer_area,
  output logic       timer_left,
  output logic [6:0] sec_left,
  output logic       time_out,
  output logic       running
);

  // Clocks per pixel of fill; 64-bit so CLK_HZ*TIME_SEC cannot overflow.
  localparam longint unsigned PIX_RAW = (64'(CLK_HZ) * 64'(TIME_SEC)) / 64'(BAR_W);
  localparam int unsigned PIX_TICKS = (PIX_RAW < 64'd1) ? 32'd1 : 32'(PIX_RAW);
  localparam int unsigned SEC_CW = (CLK_HZ > 32'd1) ? $clog2(CLK_HZ) : 32'd1;
  localparam int unsigned PIX_CW = (PIX_TICKS > 32'd1) ? $clog2(PIX_TICKS) : 32'd1;

  localparam logic [SEC_CW-1:0] SEC_LAST = SEC_CW'(CLK_HZ - 32'd1);
  localparam logic [PIX_CW-1:0] PIX_LAST = PIX_CW'(PIX_TICKS - 32'd1);
  localparam logic [6:0]        SEC_FULL = 7'(TIME_SEC);
  localparam logic [9:0]        FILL_FULL = 10'(BAR_W);
  localparam logic [10:0]       X_LO = 11'(BAR_X0);
  localparam logic [10:0]       X_HI = 11'(BAR_X0 + BAR_W);
  localparam logic [10:0]       Y_LO = 11'(BAR_Y0);
  localparam logic [10:0]       Y_HI = 11'(BAR_Y0 + BAR_H);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [SEC_CW-1:0] sec_cnt_q, sec_cnt_d;
  logic [PIX_CW-1:0] pix_cnt_q, pix_cnt_d;
  logic [6:0]        sec_left_q, sec_left_d;
  logic [9:0]        fill_w_q, fill_w_d;
  logic [9:0]        fill_disp_q, fill_disp_d;
  logic              time_out_q, time_out_d;
  logic              running_q, running_d;
  logic              area_q, area_d;
  logic              left_q, left_d;

  logic              sec_wrap_s, pix_wrap_s, expire_s;
  logic [10:0]       x_ext_s, y_ext_s;

  assign sec_wrap_s = (sec_cnt_q == SEC_LAST);
  assign pix_wrap_s = (pix_cnt_q == PIX_LAST);
  // Expiry only when this RUN cycle is not overridden by clear/start.
  assign expire_s   = (state_q == S_RUN) && sec_wrap_s && (sec_left_q == 7'd1) &&
                      !clear && !start;
  assign x_ext_s    = {1'b0, x_pixel};
  assign y_ext_s    = {1'b0, y_pixel};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear beats start beats hold, expiry beats hold.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_RUN: begin
          if (expire_s) begin
            state_d = S_EXPIRED;
          end else if (hold) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_RUN;
          end
        end
        S_PAUSE: begin
          if (hold) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_RUN;
          end
        end
        S_EXPIRED: state_d = S_EXPIRED;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs, registered so running/time_out line up with the state.
  always_comb begin
    running_d  = (state_d == S_RUN);
    time_out_d = expire_s;
  end

  // Countdown datapath: second and fill counters advance only in RUN.
  always_comb begin
    sec_cnt_d  = sec_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    sec_left_d = sec_left_q;
    fill_w_d   = fill_w_q;
    if (clear || start) begin
      sec_cnt_d  = '0;
      pix_cnt_d  = '0;
      sec_left_d = SEC_FULL;
      fill_w_d   = FILL_FULL;
    end else begin
      case (state_q)
        S_RUN: begin
          if (sec_wrap_s) begin
            sec_cnt_d  = '0;
            sec_left_d = sec_left_q - 7'd1;
          end else begin
            sec_cnt_d  = sec_cnt_q + SEC_CW'(1);
          end
          if (pix_wrap_s) begin
            pix_cnt_d = '0;
            if (fill_w_q != 10'd0) begin
              fill_w_d = fill_w_q - 10'd1;
            end else begin
              fill_w_d = 10'd0;
            end
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_CW'(1);
          end
          // Rounding of PIX_TICKS can leave pixels over; expiry empties the bar.
          if (expire_s) begin
            fill_w_d  = 10'd0;
            sec_cnt_d = '0;
            pix_cnt_d = '0;
          end else begin
            fill_w_d  = fill_w_d;
          end
        end
        S_PAUSE: begin
          sec_cnt_d = sec_cnt_q;
        end
        S_EXPIRED: begin
          sec_cnt_d  = '0;
          pix_cnt_d  = '0;
          sec_left_d = 7'd0;
          fill_w_d   = 10'd0;
        end
        default: begin
          sec_cnt_d  = '0;
          pix_cnt_d  = '0;
          sec_left_d = SEC_FULL;
          fill_w_d   = FILL_FULL;
        end
      endcase
    end
  end

  // Fill width shown on screen only changes during vertical blanking.
  always_comb begin
    if (frame_tick) begin
      fill_disp_d = fill_w_q;
    end else begin
      fill_disp_d = fill_disp_q;
    end
  end

  // Pixel flags; timer_left is a subset of timer_area by construction.
  always_comb begin
    area_d = DE && (x_ext_s >= X_LO) && (x_ext_s < X_HI) &&
             (y_ext_s >= Y_LO) && (y_ext_s < Y_HI);
    left_d = area_d && (x_ext_s < (X_LO + {1'b0, fill_disp_q}));
  end

  // Datapath, display latch and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      sec_left_q  <= SEC_FULL;
      fill_w_q    <= FILL_FULL;
      fill_disp_q <= FILL_FULL;
      time_out_q  <= 1'b0;
      running_q   <= 1'b0;
      area_q      <= 1'b0;
      left_q      <= 1'b0;
    end else begin
      sec_cnt_q   <= sec_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      sec_left_q  <= sec_left_d;
      fill_w_q    <= fill_w_d;
      fill_disp_q <= fill_disp_d;
      time_out_q  <= time_out_d;
      running_q   <= running_d;
      area_q      <= area_d;
      left_q      <= left_d;
    end
  end

  assign timer_area = area_q;
  assign timer_left = left_q;
  assign sec_left   = sec_left_q;
  assign time_out   = time_out_q;
  assign running    = running_q;

endmodule

// File: tb/tb_timer_bar_gen.sv
// Bench for timer_bar_gen with a small configuration (PIX_TICKS = 5).
// A behavioural model tracks elapsed RUN cycles and derives seconds and fill
// from them arithmetically; a compare process checks every cycle, and the
// directed sequence adds hand-computed literal expectations.
module tb_timer_bar_gen;

  localparam int CLK_HZ   = 10;
  localparam int TIME_SEC = 4;
  localparam int BAR_X0   = 2;
  localparam int BAR_Y0   = 1;
  localparam int BAR_W    = 8;
  localparam int BAR_H    = 2;
  localparam int PIX      = (CLK_HZ * TIME_SEC) / BAR_W;
  localparam int TOTAL    = CLK_HZ * TIME_SEC;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] x_pixel, y_pixel;
  logic       DE, frame_tick, start, hold, clear;
  logic       timer_area, timer_left, time_out, running;
  logic [6:0] sec_left;

  int n_chk = 0;
  int n_fail = 0;
  int run_cnt = 0;
  bit chk_en = 1'b0;

  int m_mode, m_el, m_disp;
  bit m_area, m_left, m_tout;

  timer_bar_gen #(
    .CLK_HZ(CLK_HZ), .TIME_SEC(TIME_SEC), .BAR_X0(BAR_X0),
    .BAR_Y0(BAR_Y0), .BAR_W(BAR_W), .BAR_H(BAR_H)
  ) dut (
    .clk(clk), .reset_n(reset_n), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .DE(DE), .frame_tick(frame_tick), .start(start), .hold(hold),
    .clear(clear), .timer_area(timer_area), .timer_left(timer_left),
    .sec_left(sec_left), .time_out(time_out), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_fill(input int mode, input int el);
    int f;
    if (mode == M_EXP) return 0;
    f = BAR_W - el / PIX;
    return (f < 0) ? 0 : f;
  endfunction

  function automatic int m_sec(input int mode, input int el);
    if (mode == M_EXP) return 0;
    return TIME_SEC - el / CLK_HZ;
  endfunction

  function automatic bit in_rect(input int x, input int y);
    return (x >= BAR_X0) && (x < BAR_X0 + BAR_W) && (y >= BAR_Y0) && (y < BAR_Y0 + BAR_H);
  endfunction

  // Reference model: mode plus elapsed counting cycles since the last reload.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= M_IDLE; m_el <= 0; m_disp <= BAR_W;
      m_area <= 1'b0; m_left <= 1'b0; m_tout <= 1'b0;
    end else begin
      if (clear) begin
        m_mode <= M_IDLE; m_el <= 0;
      end else if (start) begin
        m_mode <= M_RUN; m_el <= 0;
      end else if (m_mode == M_RUN) begin
        m_el <= m_el + 1;
        if (m_el + 1 == TOTAL) m_mode <= M_EXP;
        else if (hold) m_mode <= M_PAUSE;
        else m_mode <= M_RUN;
      end else if (m_mode == M_PAUSE && !hold) begin
        m_mode <= M_RUN;
      end else begin
        m_mode <= m_mode;
      end
      m_tout <= !clear && !start && (m_mode == M_RUN) && (m_el + 1 == TOTAL);
      if (frame_tick) m_disp <= m_fill(m_mode, m_el);
      m_area <= DE && in_rect(int'(x_pixel), int'(y_pixel));
      m_left <= DE && in_rect(int'(x_pixel), int'(y_pixel)) && (int'(x_pixel) < BAR_X0 + m_disp);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("area", int'(timer_area), int'(m_area));
      chk("left", int'(timer_left), int'(m_left));
      chk("sec_left", int'(sec_left), m_sec(m_mode, m_el));
      chk("time_out", int'(time_out), int'(m_tout));
      chk("running", int'(running), int'(m_mode == M_RUN));
      chk("left_implies_area", int'(timer_left & ~timer_area), 0);
    end
  end

  // Observed RUN cycles (running seen before each counting edge).
  always @(negedge clk) begin
    if (running) run_cnt++;
  end

  initial begin
    bit seen;
    reset_n = 1'b0; x_pixel = 10'd0; y_pixel = 10'd0; DE = 1'b0;
    frame_tick = 1'b0; start = 1'b0; hold = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_sec", int'(sec_left), 4);
    chk("rst_running", int'(running), 0);
    chk("rst_area", int'(timer_area), 0);
    chk("rst_time_out", int'(time_out), 0);

    // Raster sweep with no countdown: full bar, left == area.
    DE = 1'b1;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 16; x++) begin
        x_pixel = 10'(x); y_pixel = 10'(y);
        @(negedge clk);
        chk("sweep_area", int'(timer_area), int'(x >= 2 && x <= 9 && y >= 1 && y <= 2));
        chk("sweep_left", int'(timer_left), int'(timer_area));
      end
    end
    DE = 1'b0; x_pixel = 10'd3; y_pixel = 10'd1;
    @(negedge clk);
    chk("de_low_area", int'(timer_area), 0);
    DE = 1'b1;

    // Start and run 10 counting cycles.
    x_pixel = 10'd9; y_pixel = 10'd1;
    run_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("run10_sec", int'(sec_left), 3);
    chk("run10_left_x9_before_tick", int'(timer_left), 1);
    frame_tick = 1'b1; x_pixel = 10'd7;
    @(negedge clk);
    frame_tick = 1'b0; x_pixel = 10'd8;
    @(negedge clk);
    chk("fill6_left_x8", int'(timer_left), 0);
    chk("fill6_area_x8", int'(timer_area), 1);
    x_pixel = 10'd7;
    @(negedge clk);
    chk("fill6_left_x7", int'(timer_left), 1);

    // Hold for 7 cycles mid-second (14 counting cycles done).
    hold = 1'b1;
    repeat (7) @(negedge clk);
    chk("hold_running", int'(running), 0);
    chk("hold_sec", int'(sec_left), 3);
    hold = 1'b0;
    repeat (6) @(negedge clk);
    chk("resume_sec_before", int'(sec_left), 3);
    @(negedge clk);
    chk("resume_sec_after", int'(sec_left), 2);

    // Run to expiry with a bounded wait.
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (time_out) begin
        seen = 1'b1;
        break;
      end
    end
    chk("time_out_seen", int'(seen), 1);
    chk("run_cycles_to_expiry", run_cnt, 40);
    chk("expiry_sec", int'(sec_left), 0);
    @(negedge clk);
    chk("time_out_one_cycle", int'(time_out), 0);
    frame_tick = 1'b1; x_pixel = 10'd2; y_pixel = 10'd1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    chk("expired_left", int'(timer_left), 0);
    chk("expired_area", int'(timer_area), 1);

    // Restart from EXPIRED.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_sec", int'(sec_left), 4);
    chk("restart_running", int'(running), 1);
    repeat (3) @(negedge clk);

    // clear and start together: clear wins.
    clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    chk("clear_running", int'(running), 0);
    chk("clear_sec", int'(sec_left), 4);
    frame_tick = 1'b1; x_pixel = 10'd9; y_pixel = 10'd1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    chk("clear_full_left", int'(timer_left), 1);

    // Asynchronous reset mid-RUN, between edges.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; x_pixel = 10'd3;
    repeat (5) @(negedge clk);
    chk("pre_rst_area", int'(timer_area), 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_sec", int'(sec_left), 4);
    chk("arst_running", int'(running), 0);
    chk("arst_area", int'(timer_area), 0);
    chk("arst_left", int'(timer_left), 0);
    chk("arst_time_out", int'(time_out), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle_running", int'(running), 0);
    chk("post_rst_idle_sec", int'(sec_left), 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_start_running", int'(running), 1);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
